preamble_inserter: RTL

- TX-side framing block for the 802.11a/g OFDM chain.
- Prepends the legacy preamble to each payload packet arriving on an AXI-stream:
  - short training field (STF): 10 x 16 samples;
  - long training field (LTF): 32-sample cyclic prefix, then 2 x 64 samples.
- Then passes the payload through unchanged.
- The output is exactly what the RX plateau/edge detector searches for. It sits between the IFFT/cyclic-prefix stage and the radio TX stream.

---
 rtl/ofdm_preamble_pkg.sv | 32 +++
 rtl/preamble_rom.sv | 103 ++++++++++
 rtl/preamble_inserter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ofdm_preamble_pkg.sv
// rtl/ofdm_preamble_pkg.sv - shared states, symbol lengths and I/Q sample helpers for the OFDM preamble path
package ofdm_preamble_pkg;

    localparam int STF_LEN = 16;
    localparam int LTF_LEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STF,
        ST_LTF_CP,
        ST_LTF,
        ST_PAYLOAD
    } state_t;

    function automatic logic [31:0] pack_iq(input logic [15:0] i, input logic [15:0] q);
        return {i, q};
    endfunction

    // Coefficients are tabulated in thousandths of the unit-power waveform, stored x4 in Q1.14.
    function automatic logic [15:0] q14(input int milli);
        return 16'((milli * 65536) / 1000);
    endfunction

    function automatic logic [31:0] scale_sample(input logic [31:0] s, input int sh);
        logic signed [15:0] si;
        logic signed [15:0] sq;
        si = s[31:16];
        sq = s[15:0];
        return {si >>> sh, sq >>> sh};
    endfunction

endpackage

// File: rtl/preamble_rom.sv
// rtl/preamble_rom.sv - combinational 802.11a STF/LTF time-domain coefficient tables
module preamble_rom
    import ofdm_preamble_pkg::*;
(
    input  logic        sel,
    input  logic [5:0]  addr,
    output logic [31:0] sample
);

    always_comb begin
        sample = '0;
        if (!sel) begin
            case (addr[3:0])
                4'd0:  sample = pack_iq(q14(46),   q14(46));
                4'd1:  sample = pack_iq(q14(-132), q14(2));
                4'd2:  sample = pack_iq(q14(-13),  q14(-79));
                4'd3:  sample = pack_iq(q14(143),  q14(-13));
                4'd4:  sample = pack_iq(q14(92),   q14(0));
                4'd5:  sample = pack_iq(q14(143),  q14(-13));
                4'd6:  sample = pack_iq(q14(-13),  q14(-79));
                4'd7:  sample = pack_iq(q14(-132), q14(2));
                4'd8:  sample = pack_iq(q14(46),   q14(46));
                4'd9:  sample = pack_iq(q14(2),    q14(-132));
                4'd10: sample = pack_iq(q14(-79),  q14(-13));
                4'd11: sample = pack_iq(q14(-13),  q14(143));
                4'd12: sample = pack_iq(q14(0),    q14(92));
                4'd13: sample = pack_iq(q14(-13),  q14(143));
                4'd14: sample = pack_iq(q14(-79),  q14(-13));
                4'd15: sample = pack_iq(q14(2),    q14(-132));
                default: sample = '0;
            endcase
        end else begin
            case (addr)
                6'd0:  sample = pack_iq(q14(156),  q14(0));
                6'd1:  sample = pack_iq(q14(-5),   q14(-120));
                6'd2:  sample = pack_iq(q14(40),   q14(-111));
                6'd3:  sample = pack_iq(q14(97),   q14(83));
                6'd4:  sample = pack_iq(q14(21),   q14(28));
                6'd5:  sample = pack_iq(q14(60),   q14(-88));
                6'd6:  sample = pack_iq(q14(-115), q14(-55));
                6'd7:  sample = pack_iq(q14(-38),  q14(-106));
                6'd8:  sample = pack_iq(q14(98),   q14(-26));
                6'd9:  sample = pack_iq(q14(53),   q14(4));
                6'd10: sample = pack_iq(q14(1),    q14(-115));
                6'd11: sample = pack_iq(q14(-137), q14(-47));
                6'd12: sample = pack_iq(q14(24),   q14(-59));
                6'd13: sample = pack_iq(q14(59),   q14(-15));
                6'd14: sample = pack_iq(q14(-22),  q14(161));
                6'd15: sample = pack_iq(q14(119),  q14(-5));
                6'd16: sample = pack_iq(q14(62),   q14(62));
                6'd17: sample = pack_iq(q14(37),   q14(-98));
                6'd18: sample = pack_iq(q14(-57),  q14(-39));
                6'd19: sample = pack_iq(q14(-131), q14(-65));
                6'd20: sample = pack_iq(q14(82),   q14(-92));
                6'd21: sample = pack_iq(q14(70),   q14(-14));
                6'd22: sample = pack_iq(q14(-60),  q14(-81));
                6'd23: sample = pack_iq(q14(-56),  q14(22));
                6'd24: sample = pack_iq(q14(-35),  q14(151));
                6'd25: sample = pack_iq(q14(-122), q14(17));
                6'd26: sample = pack_iq(q14(-127), q14(21));
                6'd27: sample = pack_iq(q14(75),   q14(74));
                6'd28: sample = pack_iq(q14(-3),   q14(-54));
                6'd29: sample = pack_iq(q14(-92),  q14(-115));
                6'd30: sample = pack_iq(q14(92),   q14(-106));
                6'd31: sample = pack_iq(q14(12),   q14(-98));
                6'd32: sample = pack_iq(q14(-156), q14(0));
                6'd33: sample = pack_iq(q14(12),   q14(98));
                6'd34: sample = pack_iq(q14(92),   q14(106));
                6'd35: sample = pack_iq(q14(-92),  q14(115));
                6'd36: sample = pack_iq(q14(-3),   q14(54));
                6'd37: sample = pack_iq(q14(75),   q14(-74));
                6'd38: sample = pack_iq(q14(-127), q14(-21));
                6'd39: sample = pack_iq(q14(-122), q14(-17));
                6'd40: sample = pack_iq(q14(-35),  q14(-151));
                6'd41: sample = pack_iq(q14(-56),  q14(-22));
                6'd42: sample = pack_iq(q14(-60),  q14(81));
                6'd43: sample = pack_iq(q14(70),   q14(14));
                6'd44: sample = pack_iq(q14(82),   q14(92));
                6'd45: sample = pack_iq(q14(-131), q14(65));
                6'd46: sample = pack_iq(q14(-57),  q14(39));
                6'd47: sample = pack_iq(q14(37),   q14(98));
                6'd48: sample = pack_iq(q14(62),   q14(-62));
                6'd49: sample = pack_iq(q14(119),  q14(4));
                6'd50: sample = pack_iq(q14(-22),  q14(-161));
                6'd51: sample = pack_iq(q14(59),   q14(15));
                6'd52: sample = pack_iq(q14(24),   q14(59));
                6'd53: sample = pack_iq(q14(-137), q14(47));
                6'd54: sample = pack_iq(q14(1),    q14(115));
                6'd55: sample = pack_iq(q14(53),   q14(-4));
                6'd56: sample = pack_iq(q14(98),   q14(25));
                6'd57: sample = pack_iq(q14(-38),  q14(106));
                6'd58: sample = pack_iq(q14(-115), q14(55));
                6'd59: sample = pack_iq(q14(60),   q14(88));
                6'd60: sample = pack_iq(q14(21),   q14(-28));
                6'd61: sample = pack_iq(q14(97),   q14(-83));
                6'd62: sample = pack_iq(q14(40),   q14(111));
                6'd63: sample = pack_iq(q14(-5),   q14(120));
                default: sample = '0;
            endcase
        end
    end

endmodule

// File: rtl/preamble_inserter.sv
// rtl/preamble_inserter.sv - prepends the legacy STF/LTF preamble to each AXI-stream payload packet
module preamble_inserter
    import ofdm_preamble_pkg::*;
#(
    parameter int STF_REPS    = 10,
    parameter int LTF_CP_LEN  = 32,
    parameter int LTF_REPS    = 2,
    parameter int SCALE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        busy
);

    localparam logic [6:0] CP_START     = 7'(LTF_LEN - LTF_CP_LEN);
    localparam logic [6:0] STF_LAST     = 7'(STF_LEN - 1);
    localparam logic [6:0] LTF_LAST     = 7'(LTF_LEN - 1);
    localparam logic [3:0] STF_REP_LAST = 4'(STF_REPS - 1);
    localparam logic [3:0] LTF_REP_LAST = 4'(LTF_REPS - 1);

    state_t      state;
    logic [6:0]  cnt;
    logic [3:0]  rep;
    logic [5:0]  rom_addr;
    logic [31:0] rom_sample;
    logic        fire;

    assign rom_addr = (state == ST_STF) ? {2'b00, cnt[3:0]} : cnt[5:0];

    preamble_rom u_rom (
        .sel    (state != ST_STF),
        .addr   (rom_addr),
        .sample (rom_sample)
    );

    // Preamble words come straight from the held counter, so they stay stable under backpressure.
    always_comb begin
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = '0;
        i_tready = 1'b0;
        case (state)
            ST_STF, ST_LTF_CP, ST_LTF: begin
                o_tvalid = 1'b1;
                o_tdata  = scale_sample(rom_sample, SCALE_SHIFT);
            end
            ST_PAYLOAD: begin
                o_tvalid = i_tvalid;
                o_tlast  = i_tlast;
                o_tdata  = i_tdata;
                i_tready = o_tready;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign fire = o_tvalid && o_tready;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rep   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tvalid) begin
                        state <= ST_STF;
                        cnt   <= '0;
                        rep   <= '0;
                    end
                end
                ST_STF: begin
                    if (fire) begin
                        if (cnt == STF_LAST) begin
                            cnt <= '0;
                            if (rep == STF_REP_LAST) begin
                                rep <= '0;
                                if (LTF_CP_LEN == 0) begin
                                    state <= ST_LTF;
                                end else begin
                                    state <= ST_LTF_CP;
                                    cnt   <= CP_START;
                                end
                            end else begin
                                rep <= rep + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                ST_LTF_CP: begin
                    if (fire) begin
                        if (cnt == LTF_LAST) begin
                            state <= ST_LTF;
                            cnt   <= '0;
                            rep   <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                ST_LTF: begin
                    if (fire) begin
                        if (cnt == LTF_LAST) begin
                            cnt <= '0;
                            if (rep == LTF_REP_LAST) begin
                                state <= ST_PAYLOAD;
                                rep   <= '0;
                            end else begin
                                rep <= rep + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (fire && i_tlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
